// File: rtl/mul_result.sv
// mul_result: multiply-op control pipe E->M, result select/sign-extend in M, M->W result register, retire counter
module mul_result #(
   parameter int XLEN = 64,
   parameter int CNTW = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              StallM,
   input  logic              FlushM,
   input  logic              StallW,
   input  logic              FlushW,
   input  logic              MulE,
   input  logic [2:0]        Funct3E,
   input  logic              W64E,
   input  logic [2*XLEN-1:0] ProdM,
   output logic              MulValidM,
   output logic [XLEN-1:0]   MulResultM,
   output logic              MulValidW,
   output logic [XLEN-1:0]   MulResultW,
   output logic [CNTW-1:0]   MulRetireCnt
);
   logic            valid_m_q, valid_m_d;
   logic [2:0]      funct3_m_q, funct3_m_d;
   logic            w64_m_q, w64_m_d;
   logic [XLEN-1:0] sext_w;
   logic [XLEN-1:0] result_m;
   logic            valid_w_q, valid_w_d;
   logic [XLEN-1:0] result_w_q, result_w_d;
   logic            retire;
   logic [CNTW-1:0] cnt_q, cnt_d;

   // E->M control: hold while stalled, otherwise load op or bubble on flush; word ops exist only on RV64
   always_comb begin
      valid_m_d  = StallM ? valid_m_q  : ~FlushM & MulE;
      funct3_m_d = StallM ? funct3_m_q : (FlushM ? 3'b000 : Funct3E);
      w64_m_d    = StallM ? w64_m_q    : ~FlushM & W64E & (XLEN == 64);
   end

   // E->M control register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_m_q  <= 1'b0;
         funct3_m_q <= 3'b000;
         w64_m_q    <= 1'b0;
      end else begin
         valid_m_q  <= valid_m_d;
         funct3_m_q <= funct3_m_d;
         w64_m_q    <= w64_m_d;
      end
   end

   // Result select: low half for mul (sign-extended word for mulw), high half for mulh*, zero otherwise
   always_comb begin
      sext_w   = XLEN'($signed(ProdM[31:0]));
      result_m = (!valid_m_q || funct3_m_q[2]) ? '0 :
                 (funct3_m_q[1:0] != 2'b00)    ? ProdM[2*XLEN-1:XLEN] :
                 w64_m_q                       ? sext_w : ProdM[XLEN-1:0];
   end

   // M->W next state: hold while stalled, otherwise capture M or bubble on flush
   always_comb begin
      valid_w_d  = StallW ? valid_w_q  : ~FlushW & valid_m_q;
      result_w_d = StallW ? result_w_q : (FlushW ? '0 : result_m);
      retire     = valid_w_q & ~StallW & ~FlushW;
      cnt_d      = cnt_q + CNTW'(retire);
   end

   // M->W result register and retire counter (counter wraps naturally)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_w_q  <= 1'b0;
         result_w_q <= '0;
         cnt_q      <= '0;
      end else begin
         valid_w_q  <= valid_w_d;
         result_w_q <= result_w_d;
         cnt_q      <= cnt_d;
      end
   end

   assign MulValidM    = valid_m_q;
   assign MulResultM   = result_m;
   assign MulValidW    = valid_w_q;
   assign MulResultW   = result_w_q;
   assign MulRetireCnt = cnt_q;
endmodule

// File: tb/tb_mul_result.sv
// tb_mul_result: scoreboard bench for mul_result (XLEN=64, CNTW=32 plus a CNTW=4 copy for counter wrap)
module tb_mul_result;
   logic         clk = 1'b0;
   logic         reset_n;
   logic         StallM, FlushM, StallW, FlushW;
   logic         MulE, W64E;
   logic [2:0]   Funct3E;
   logic [127:0] ProdM;
   logic         MulValidM, MulValidW, valid_m4, valid_w4;
   logic [63:0]  MulResultM, MulResultW, result_m4, result_w4;
   logic [31:0]  MulRetireCnt;
   logic [3:0]   cnt4;

   int checks = 0;
   int failures = 0;
   logic [63:0]  q[$];
   logic         m_valid, m_w64, w_valid;
   logic [2:0]   m_f3;
   logic [127:0] m_prod;
   logic [63:0]  w_exp;
   logic [31:0]  cnt;

   mul_result #(.XLEN(64), .CNTW(32)) dut (
      .clk(clk), .reset_n(reset_n), .StallM(StallM), .FlushM(FlushM), .StallW(StallW), .FlushW(FlushW),
      .MulE(MulE), .Funct3E(Funct3E), .W64E(W64E), .ProdM(ProdM),
      .MulValidM(MulValidM), .MulResultM(MulResultM), .MulValidW(MulValidW), .MulResultW(MulResultW),
      .MulRetireCnt(MulRetireCnt)
   );

   mul_result #(.XLEN(64), .CNTW(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .StallM(StallM), .FlushM(FlushM), .StallW(StallW), .FlushW(FlushW),
      .MulE(MulE), .Funct3E(Funct3E), .W64E(W64E), .ProdM(ProdM),
      .MulValidM(valid_m4), .MulResultM(result_m4), .MulValidW(valid_w4), .MulResultW(result_w4),
      .MulRetireCnt(cnt4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_sel(input logic v, input logic [2:0] f3, input logic w64, input logic [127:0] p);
      if (!v || f3[2]) return 64'd0;
      if (f3 == 3'b000) return w64 ? {{32{p[31]}}, p[31:0]} : p[63:0];
      return p[127:64];
   endfunction

   // one cycle: drive E op and controls, check M/W/counter mid-cycle, then advance the scoreboard
   task automatic step(input logic mul, input logic [2:0] f3, input logic w64, input logic [127:0] prod,
                       input logic stm, input logic flm, input logic stw, input logic flw);
      MulE = mul; Funct3E = f3; W64E = w64; ProdM = m_prod;
      StallM = stm; FlushM = flm; StallW = stw; FlushW = flw;
      @(negedge clk);
      check("valid_m", MulValidM, m_valid);
      check("res_m", MulResultM, ref_sel(m_valid, m_f3, m_w64, m_prod));
      check("valid_w", MulValidW, w_valid);
      check("res_w", MulResultW, w_exp);
      check("cnt", MulRetireCnt, cnt);
      check(cnt[3:0] == 4'd0 ? "cnt4_wrap" : "cnt4", cnt4, cnt[3:0]);
      check("valid_w4", valid_w4, w_valid);
      check("res_w4", result_w4, w_exp);
      @(posedge clk);
      #1;
      if (!stw) begin
         if (w_valid && !flw) cnt++;
         if (flw) begin
            if (m_valid) begin
               check("sb_depth", q.size() != 0, 1'b1);
               if (q.size() != 0) void'(q.pop_front());
            end
            w_valid = 1'b0;
            w_exp = 64'd0;
         end else begin
            w_valid = m_valid;
            w_exp = 64'd0;
            if (m_valid) begin
               check("sb_depth", q.size() != 0, 1'b1);
               if (q.size() != 0) w_exp = q.pop_front();
            end
         end
      end
      if (!stm) begin
         m_valid = !flm && mul;
         m_f3 = flm ? 3'b000 : f3;
         m_w64 = !flm && w64;
         m_prod = prod;
         if (m_valid) q.push_back(ref_sel(1'b1, f3, w64, prod));
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_valid_m", MulValidM, 1'b0);
      check("rst_res_m", MulResultM, 64'd0);
      check("rst_valid_w", MulValidW, 1'b0);
      check("rst_res_w", MulResultW, 64'd0);
      check("rst_cnt", MulRetireCnt, 32'd0);
      check("rst_cnt4", cnt4, 4'd0);
      q.delete();
      m_valid = 1'b0; m_f3 = 3'b000; m_w64 = 1'b0; m_prod = '0;
      w_valid = 1'b0; w_exp = 64'd0; cnt = 32'd0;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      logic [127:0] p1, p3;
      logic         s;
      p1 = 128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFF1;
      p3 = {64'h1234_5678_9ABC_DEF0, 64'h0000_0001_8000_0000};
      reset_n = 1'b0;
      MulE = 1'b0; Funct3E = 3'b000; W64E = 1'b0; ProdM = '1;
      StallM = 1'b0; FlushM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
      #2;
      do_reset();
      step(1'b1, 3'b000, 1'b0, p1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b001, 1'b0, p1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b000, 1'b1, p3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b011, 1'b1, p3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b101, 1'b0, p1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b010, 1'b0, p1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 3'b000, 1'b0, p3, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b000, 1'b0, p1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b001, 1'b0, p1, 1'b0, 1'b0, 1'b0, 1'b0);
      ProdM = m_prod;
      #2;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         s = ($urandom % 6) == 0;
         step(($urandom % 4) != 0, 3'($urandom_range(0, 4)), 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
              s, ($urandom % 8) == 0, s, ($urandom % 10) == 0);
      end
      for (int i = 0; i < 20; i++) step(1'b1, 3'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                                        1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
